// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts WIDTH-bit words on a valid/ready handshake and
// streams them one bit per clock on x_out, with a one-word holding register so
// consecutive words stream back to back.
// Latency: first bit of a word accepted at edge E appears in the cycle after E.
// Backpressure: data_ready drops while the holding register is occupied.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             shifting;
  logic             last_bit;
  logic             shifter_free;
  logic             accept;
  logic             cur_bit;
  logic [WIDTH-1:0] sh_shifted;

  assign shifting     = (state_q == ST_SHIFT);
  assign last_bit     = shifting && (cnt_q == LAST_CNT);
  // The shifter can take a new word at the edge that retires the last bit.
  assign shifter_free = !shifting || last_bit;

  // Ready is forced low during reset so nothing is accepted while rst is high.
  assign data_ready = !hold_full_q && !rst;
  assign accept     = data_valid && data_ready;

  // Direction-dependent serial tap and shift; vacated bits fill with zero.
  always_comb begin
    if (MSB_FIRST) begin
      cur_bit    = sh_q[WIDTH-1];
      sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      cur_bit    = sh_q[0];
      sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  // Next-state: shift/count, end-of-word refill from hold, and load routing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (shifting) begin
      sh_d  = sh_shifted;
      cnt_d = cnt_q + CW'(1);
    end

    if (last_bit) begin
      if (hold_full_q) begin
        // Holding register has priority; accept is impossible while it is full.
        sh_d        = hold_q;
        hold_full_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_SHIFT;
      end else begin
        // Word finished; a direct load below may override this.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end

    if (accept) begin
      if (shifter_free && !hold_full_q) begin
        sh_d    = data_in;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end else begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any partial word and the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Output qualification: x_out is held at 0 outside valid bits.
  always_comb begin
    x_valid     = shifting;
    x_out       = shifting && cur_bit;
    frame_start = shifting && (cnt_q == '0);
    busy        = shifting || hold_full_q;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: one MSB-first and one LSB-first
// instance sharing clock and reset, checked cycle by cycle against
// hand-derived bit streams.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] a_din   = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_rdy, a_xo, a_xv, a_fs, a_bs;

  logic [7:0] b_din   = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_rdy, b_xo, b_xv, b_fs, b_bs;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(a_din), .data_valid(a_valid),
    .data_ready(a_rdy), .x_out(a_xo), .x_valid(a_xv),
    .frame_start(a_fs), .busy(a_bs)
  );

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(b_din), .data_valid(b_valid),
    .data_ready(b_rdy), .x_out(b_xo), .x_valid(b_xv),
    .frame_start(b_fs), .busy(b_bs)
  );

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic       xo;
    logic       xv;
    logic       fs;
    logic       bs;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then check the outputs.
  task automatic row(input bit sel, input logic [7:0] din, input logic vld,
                     input logic exo, input logic exv, input logic efs,
                     input logic ebs, input logic erdy, input string nm);
    if (!sel) begin
      a_din = din; a_valid = vld;
    end else begin
      b_din = din; b_valid = vld;
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      chk({nm, ".x_out"}, a_xo, exo);
      chk({nm, ".x_valid"}, a_xv, exv);
      chk({nm, ".frame_start"}, a_fs, efs);
      chk({nm, ".busy"}, a_bs, ebs);
      chk({nm, ".data_ready"}, a_rdy, erdy);
    end else begin
      chk({nm, ".x_out"}, b_xo, exo);
      chk({nm, ".x_valid"}, b_xv, exv);
      chk({nm, ".frame_start"}, b_fs, efs);
      chk({nm, ".busy"}, b_bs, ebs);
      chk({nm, ".data_ready"}, b_rdy, erdy);
    end
  endtask

  task automatic chk_quiet(input string nm, input logic erdy);
    chk({nm, ".a_x_out"}, a_xo, 1'b0);
    chk({nm, ".a_x_valid"}, a_xv, 1'b0);
    chk({nm, ".a_frame_start"}, a_fs, 1'b0);
    chk({nm, ".a_busy"}, a_bs, 1'b0);
    chk({nm, ".a_data_ready"}, a_rdy, erdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  bits_a5;
    logic [23:0] pat_b2b;
    logic [7:0]  pat_c3;
    logic [7:0]  pat_06_lsb;
    vec_t v;

    // A5 MSB first, and the F0/0F/3C stream, as emitted bit order.
    bits_a5    = 8'b1010_0101;
    pat_b2b    = 24'b11110000_00001111_00111100;
    pat_c3     = 8'b1100_0011;
    pat_06_lsb = 8'b0110_0000;

    // Single A5 word: edge 0 accepts, bits after edges 0..7, idle after edge 8.
    for (int k = 0; k < 9; k++) begin
      v.din = 8'hA5;
      v.vld = (k == 0);
      v.xo  = (k < 8) ? bits_a5[7-k] : 1'b0;
      v.xv  = (k < 8);
      v.fs  = (k == 0);
      v.bs  = (k < 8);
      v.rdy = 1'b1;
      tbl.push_back(v);
    end
    // Back to back: F0 direct, 0F into hold at edge 1, 3C offered from edge 2
    // but only accepted at edge 9 once hold drained at edge 8.
    for (int k = 0; k < 25; k++) begin
      v.din = (k == 0) ? 8'hF0 : (k == 1) ? 8'h0F : 8'h3C;
      v.vld = (k < 10);
      v.xo  = (k < 24) ? pat_b2b[23-k] : 1'b0;
      v.xv  = (k < 24);
      v.fs  = (k == 0) || (k == 8) || (k == 16);
      v.bs  = (k < 24);
      v.rdy = (k == 0) || (k == 8) || (k >= 16);
      tbl.push_back(v);
    end

    // Reset state, asynchronous.
    rst = 1'b1;
    #1;
    chk_quiet("rst_async", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("rst_held", 1'b0);
    chk("rst_held.b_busy", b_bs, 1'b0);
    chk("rst_held.b_data_ready", b_rdy, 1'b0);
    rst = 1'b0;
    #1;
    chk_quiet("rst_release", 1'b1);
    chk("rst_release.b_data_ready", b_rdy, 1'b1);

    // Table-driven single word and back-to-back streaming.
    foreach (tbl[i]) begin
      row(1'b0, tbl[i].din, tbl[i].vld, tbl[i].xo, tbl[i].xv, tbl[i].fs,
          tbl[i].bs, tbl[i].rdy, $sformatf("tbl[%0d]", i));
    end

    // Gap: FF, four idle cycles, then 80.
    for (int k = 0; k < 21; k++) begin
      logic exv;
      exv = (k < 8) || (k >= 12 && k < 20);
      row(1'b0, (k == 0) ? 8'hFF : 8'h80, (k == 0) || (k == 12),
          (k < 8) || (k == 12), exv, (k == 0) || (k == 12), exv, 1'b1,
          $sformatf("gap[%0d]", k));
    end

    // Reset during bit 3 of AA.
    row(1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "aa[0]");
    row(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "aa[1]");
    row(1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "aa[2]");
    row(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "aa[3]");
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("midrst_async", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("midrst_held", 1'b0);
    rst = 1'b0;
    #1;
    chk_quiet("midrst_release", 1'b1);
    for (int k = 0; k < 10; k++) begin
      row(1'b0, 8'hC3, (k == 0), (k < 8) ? pat_c3[7-k] : 1'b0, (k < 8),
          (k == 0), (k < 8), 1'b1, $sformatf("c3[%0d]", k));
    end

    // LSB-first instance: 01 gives a single leading 1, busy for 8 cycles.
    for (int k = 0; k < 10; k++) begin
      row(1'b1, 8'h01, (k == 0), (k == 0), (k < 8), (k == 0), (k < 8), 1'b1,
          $sformatf("lsb01[%0d]", k));
    end
    // LSB-first 06 emits 0,1,1,0,0,0,0,0.
    for (int k = 0; k < 9; k++) begin
      row(1'b1, 8'h06, (k == 0), (k < 8) ? pat_06_lsb[7-k] : 1'b0, (k < 8),
          (k == 0), (k < 8), 1'b1, $sformatf("lsb06[%0d]", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial feeder that accepts WIDTH-bit words over a valid/ready handshake and streams them one bit per clock onto a single serial line. It sits directly upstream of the Chapter 5 serial Mealy state machines and drives their `x_in` input, so benches and higher-level designs can supply bytes instead of hand-written bit sequences. A one-word holding register lets consecutive words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `data_in`  in  WIDTH  word to serialize.
- `data_valid`  in  1  `data_in` is presented.
- `data_ready`  out  1  feeder can accept a word this cycle.
- `x_out`  out  1  serial bit, connects to the downstream `x_in`.
- `x_valid`  out  1  `x_out` carries a word bit this cycle.
- `frame_start`  out  1  high on the first bit of each word.
- `busy`  out  1  shifter active or holding register occupied.

## Operation
- Storage: shift register `sh` (WIDTH), bit counter `cnt` (clog2(WIDTH) bits), holding register `hold` plus `hold_full` flag.
- States:
  - IDLE: no word in the shifter.
  - SHIFT: the shifter is emitting `cnt`-th bit; `cnt` runs 0..WIDTH-1.
- Accept: a word is accepted on a rising edge where `data_valid && data_ready`. `data_ready = !hold_full && !rst` (combinational).
- Load routing of an accepted word at edge E:
  - If the shifter is free at E (state IDLE, or SHIFT with `cnt == WIDTH-1`) and `hold_full == 0`: load directly into `sh`, set `cnt = 0`, state becomes SHIFT.
  - Otherwise: write into `hold` and set `hold_full`.
- End of word: at an edge where state is SHIFT and `cnt == WIDTH-1`:
  - If `hold_full`, move `hold` into `sh`, clear `hold_full`, set `cnt = 0`, and stay in SHIFT.
  - Else, if a direct load also occurs at this edge, take that load.
  - Else, go to IDLE.
- Hold and direct load never collide at one edge: `data_ready` is 0 whenever `hold_full` is 1.
- Shift order:
  - MSB_FIRST=1: `x_out = sh[WIDTH-1]`, shift left each SHIFT cycle.
  - MSB_FIRST=0: `x_out = sh[0]`, shift right each SHIFT cycle.
  - Vacated bits fill with 0.
- Output qualification:
  - `x_valid = (state == SHIFT)`.
  - `frame_start = x_valid && cnt == 0`.
  - `x_out` is forced to 0 whenever `x_valid` is 0, so the downstream FSM never sees X.
  - `busy = x_valid || hold_full`.
- Counter wrap: `cnt` never exceeds WIDTH-1. It resets to 0 on every load and is not advanced in IDLE.

## Timing
- Reset values while `rst` is high, taking effect immediately:
  - state IDLE, `cnt` = 0, `hold_full` = 0, `sh` = 0.
  - `x_out` = 0, `x_valid` = 0, `frame_start` = 0, `busy` = 0, `data_ready` = 0.
- First cycle after `rst` falls: `data_ready` = 1.
- Latency: a word accepted at edge E into an idle feeder drives its first bit in the cycle following E. Bit k appears in cycle E+1+k; `x_valid` falls after edge E+WIDTH if nothing follows.
- Throughput: with `data_valid` held high, words stream with `x_valid` continuously 1 and exactly WIDTH cycles per word.
- `data_ready` back-pressure:
  - Drops the cycle after a word lands in `hold`.
  - Rises the cycle after `hold` drains into `sh`.
- Mid-word reset: `rst` asserted at any point discards `sh` and `hold` without completing the word. Outputs take their reset values asynchronously, with no partial word after release.
- `data_in` is sampled only at the accept edge and may change freely otherwise.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, `data_in`=8'hA5 accepted at edge E -> `x_out` = 1,0,1,0,0,1,0,1 in cycles E+1..E+8. `frame_start` high only in E+1. `x_valid` 0 from E+9 and `x_out` 0 there.
- LSB first, MSB_FIRST=0, `data_in`=8'h01 -> `x_out` = 1,0,0,0,0,0,0,0 and `busy` 1 for exactly 8 cycles.
- Back-to-back, `data_valid` held 1 with 8'hF0, 8'h0F, 8'h3C:
  - `x_valid` stays 1 for 24 consecutive cycles.
  - Bit pattern is 11110000 00001111 00111100.
  - `frame_start` fires on cycles 1, 9 and 17.
  - `data_ready` is 0 while `hold_full` is 1 and never accepts a word that would overwrite `hold`.
- Gap handling: 8'hFF accepted, `data_valid` then 0 for 4 cycles, then 8'h80 -> 8 ones, then 4 cycles of `x_valid`=0 / `x_out`=0, then 1 followed by seven 0s.
- Reset mid-word: assert `rst` during bit 3 of 8'hAA -> `x_valid`, `x_out` and `busy` go 0 immediately. After release, the first accepted 8'hC3 streams 11000011 with no residue from 8'hAA.
- Integration: feed the downstream 5-state serial FSM from `x_out` with the byte sequence for the textbook input stream -> the FSM's `y_out` trace matches the hand-derived Mealy sequence bit for bit.
